// File: rtl/inst_fetch_pkg.sv
// Shared definitions for the instruction fetch unit: widths, state encoding,
// reset level and the little-endian word packing helper.
package inst_fetch_pkg;

    localparam int AddrWidth    = 32;
    localparam int InstWidth    = 32;
    localparam int BytesPerInst = 4;
    localparam int CntWidth     = 3;

    localparam logic [InstWidth-1:0] ZeroWord  = '0;
    localparam logic                 RstActive = 1'b0;

    localparam logic [CntWidth-1:0] CntFull = 3'd4;
    localparam logic [CntWidth-1:0] CntLast = 3'd3;
    localparam logic [AddrWidth-1:0] PcStep = 32'd4;

    typedef enum logic {
        StFetch = 1'b0,
        StOut   = 1'b1
    } fetchState_e;

    // Byte 0 arrives first and sits in the least significant position.
    function automatic logic [InstWidth-1:0] packWord(
        input logic [7:0] b0,
        input logic [7:0] b1,
        input logic [7:0] b2,
        input logic [7:0] b3
    );
        return {b3, b2, b1, b0};
    endfunction

endpackage

// File: rtl/inst_assemble.sv
// Collects the four bytes of an instruction as they return from memory,
// one cycle after each fetch request was issued.
module inst_assemble
    import inst_fetch_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_clear,
    input  logic                 i_rd,
    input  logic [7:0]           i_data,
    output logic                 o_last_byte,
    output logic [InstWidth-1:0] o_word
);

    logic [3:0][7:0]      r_buf;
    logic [CntWidth-1:0]  r_recv_cnt;
    logic                 r_req_q;
    logic                 w_capture;

    assign w_capture   = r_req_q && (r_recv_cnt != CntFull);
    assign o_last_byte = w_capture && (r_recv_cnt == CntLast);
    assign o_word      = packWord(r_buf[0], r_buf[1], r_buf[2], r_buf[3]);

    // A clear drops the byte in flight, so a redirect never mixes old and new bytes.
    always_ff @(posedge clk or negedge rst) begin
        if (rst == RstActive) begin
            r_req_q    <= 1'b0;
            r_recv_cnt <= '0;
        end else if (i_clear) begin
            r_req_q    <= 1'b0;
            r_recv_cnt <= '0;
        end else begin
            r_req_q <= i_rd;
            if (w_capture) begin
                r_recv_cnt <= r_recv_cnt + 3'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (rst == RstActive) begin
            r_buf <= ZeroWord;
        end else if (!i_clear && w_capture) begin
            r_buf[r_recv_cnt[1:0]] <= i_data;
        end
    end

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch: issues four byte reads per instruction over a shared
// memory port, then presents the assembled word until downstream accepts it.
module inst_fetch
    import inst_fetch_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 mem_busy_i,
    input  logic [7:0]           mem_data_i,
    output logic                 mem_rd_o,
    output logic [AddrWidth-1:0] mem_addr_o,
    input  logic                 stall_i,
    input  logic                 branch_enable_i,
    input  logic [AddrWidth-1:0] branch_addr_i,
    output logic [AddrWidth-1:0] pc_o,
    output logic [InstWidth-1:0] inst_o,
    output logic                 inst_valid_o
);

    fetchState_e          r_state;
    fetchState_e          w_next_state;
    logic [AddrWidth-1:0] r_pc;
    logic [CntWidth-1:0]  r_issue_cnt;
    logic                 w_issue;
    logic                 w_release;
    logic                 w_clear;
    logic                 w_last_byte;
    logic [InstWidth-1:0] w_word;

    assign w_release = (r_state == StOut) && !stall_i;
    assign w_clear   = branch_enable_i || w_release;

    inst_assemble u_assemble (
        .clk         (clk),
        .rst         (rst),
        .i_clear     (w_clear),
        .i_rd        (w_issue),
        .i_data      (mem_data_i),
        .o_last_byte (w_last_byte),
        .o_word      (w_word)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (rst == RstActive) begin
            r_state <= StFetch;
        end else begin
            r_state <= w_next_state;
        end
    end

    // A redirect wins over both completion and stall.
    always_comb begin
        w_next_state = r_state;
        if (branch_enable_i) begin
            w_next_state = StFetch;
        end else begin
            case (r_state)
                StFetch: if (w_last_byte) w_next_state = StOut;
                StOut:   if (!stall_i)    w_next_state = StFetch;
                default:                  w_next_state = StFetch;
            endcase
        end
    end

    // The reset term keeps the request low while reset is held.
    always_comb begin
        w_issue      = (r_state == StFetch) && (r_issue_cnt != CntFull) &&
                       !mem_busy_i && !branch_enable_i && (rst != RstActive);
        mem_rd_o     = w_issue;
        mem_addr_o   = r_pc + AddrWidth'(r_issue_cnt);
        inst_valid_o = (r_state == StOut) && !branch_enable_i;
        pc_o         = r_pc;
        inst_o       = w_word;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (rst == RstActive) begin
            r_pc        <= ZeroWord;
            r_issue_cnt <= '0;
        end else if (branch_enable_i) begin
            r_pc        <= branch_addr_i;
            r_issue_cnt <= '0;
        end else if (w_release) begin
            r_pc        <= r_pc + PcStep;
            r_issue_cnt <= '0;
        end else if (w_issue) begin
            r_issue_cnt <= r_issue_cnt + 3'd1;
        end
    end

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: a byte memory answers each request one cycle later; directed
// scenarios queue the expected requests and words, a negedge monitor drains the queues.
module tb_inst_fetch;

    logic        clk;
    logic        rst;
    logic        mem_busy_i;
    logic [7:0]  mem_data_i = 8'h00;
    logic        mem_rd_o;
    logic [31:0] mem_addr_o;
    logic        stall_i;
    logic        branch_enable_i;
    logic [31:0] branch_addr_i;
    logic [31:0] pc_o;
    logic [31:0] inst_o;
    logic        inst_valid_o;

    typedef struct {
        int          cyc;
        logic [31:0] addr;
    } reqExp_t;

    typedef struct {
        int          cyc;
        logic [31:0] pc;
        logic [31:0] inst;
    } outExp_t;

    reqExp_t     reqQ[$];
    outExp_t     outQ[$];
    logic [7:0]  mem [logic [31:0]];
    int          cyc = 0;
    int          base = 0;
    int          compared = 0;
    int          mismatched = 0;
    logic        pendRd = 1'b0;
    logic [31:0] pendAddr = 32'h0;

    inst_fetch dut (
        .clk             (clk),
        .rst             (rst),
        .mem_busy_i      (mem_busy_i),
        .mem_data_i      (mem_data_i),
        .mem_rd_o        (mem_rd_o),
        .mem_addr_o      (mem_addr_o),
        .stall_i         (stall_i),
        .branch_enable_i (branch_enable_i),
        .branch_addr_i   (branch_addr_i),
        .pc_o            (pc_o),
        .inst_o          (inst_o),
        .inst_valid_o    (inst_valid_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    function automatic logic [7:0] memRead(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return 8'h00;
    endfunction

    // The byte for last cycle's request is valid through the edge that ends this cycle.
    always @(negedge clk) begin
        mem_data_i = pendRd ? memRead(pendAddr) : 8'hEE;
        pendRd     = mem_rd_o;
        pendAddr   = mem_addr_o;
    end

    always @(negedge clk) begin
        reqExp_t re;
        outExp_t oe;
        if (rst) begin
            if (mem_rd_o) begin
                compared++;
                if (reqQ.size() == 0) begin
                    mismatched++;
                    $display("[TB] FAIL req: unexpected request cycle %0d addr %h", cyc, mem_addr_o);
                end else begin
                    re = reqQ.pop_front();
                    if (re.cyc != cyc || re.addr !== mem_addr_o) begin
                        mismatched++;
                        $display("[TB] FAIL req: got cycle %0d addr %h, expected cycle %0d addr %h",
                                 cyc, mem_addr_o, re.cyc, re.addr);
                    end
                end
            end
            if (inst_valid_o) begin
                compared++;
                if (outQ.size() == 0) begin
                    mismatched++;
                    $display("[TB] FAIL out: unexpected valid cycle %0d pc %h inst %h", cyc, pc_o, inst_o);
                end else begin
                    oe = outQ.pop_front();
                    if (oe.cyc != cyc || oe.pc !== pc_o || oe.inst !== inst_o) begin
                        mismatched++;
                        $display("[TB] FAIL out: got cycle %0d pc %h inst %h, expected cycle %0d pc %h inst %h",
                                 cyc, pc_o, inst_o, oe.cyc, oe.pc, oe.inst);
                    end
                end
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, " mem_rd_o"}, {31'b0, mem_rd_o}, 32'h0);
        checkOutput({tag, " inst_valid_o"}, {31'b0, inst_valid_o}, 32'h0);
        checkOutput({tag, " pc_o"}, pc_o, 32'h0);
        checkOutput({tag, " inst_o"}, inst_o, 32'h0);
    endtask

    task automatic applyStimulus(input logic busy, input logic stall, input logic br,
                                 input logic [31:0] target, input int n);
        for (int i = 0; i < n; i++) begin
            mem_busy_i      = busy;
            stall_i         = stall;
            branch_enable_i = br;
            branch_addr_i   = target;
            @(posedge clk);
            #1;
        end
        mem_busy_i      = 1'b0;
        stall_i         = 1'b0;
        branch_enable_i = 1'b0;
        branch_addr_i   = 32'h0;
    endtask

    task automatic expectReq(input int off, input logic [31:0] addr);
        reqQ.push_back('{base + off, addr});
    endtask

    task automatic expectOut(input int off, input logic [31:0] pc, input logic [31:0] inst);
        outQ.push_back('{base + off, pc, inst});
    endtask

    task automatic loadWord(input logic [31:0] addr, input logic [31:0] word);
        for (int i = 0; i < 4; i++) begin
            mem[addr + 32'(i)] = word[8*i +: 8];
        end
    endtask

    initial begin
        rst             = 1'b0;
        mem_busy_i      = 1'b0;
        stall_i         = 1'b0;
        branch_enable_i = 1'b0;
        branch_addr_i   = 32'h0;

        loadWord(32'h0000_0000, 32'h0010_0513);
        loadWord(32'h0000_0004, 32'h0020_0593);
        loadWord(32'h0000_0008, 32'h00B5_06B3);
        loadWord(32'h0000_000C, 32'hDDCC_BBAA);
        loadWord(32'h0000_0100, 32'h0000_006F);
        loadWord(32'hFFFF_FFFC, 32'h0000_1237);

        repeat (3) @(posedge clk);
        #1;
        checkResetState("reset");

        rst  = 1'b1;
        base = cyc;

        // Plain fetch, then held in OUT by three stall cycles.
        for (int i = 0; i < 4; i++) expectReq(i, 32'(i));
        for (int i = 5; i <= 8; i++) expectOut(i, 32'h0, 32'h0010_0513);
        for (int i = 0; i < 4; i++) expectReq(9 + i, 32'h4 + 32'(i));
        expectOut(14, 32'h4, 32'h0020_0593);
        // Busy in the third fetch cycle pushes address 0xA back by one.
        expectReq(15, 32'h8);
        expectReq(16, 32'h9);
        expectReq(18, 32'hA);
        expectReq(19, 32'hB);
        expectOut(21, 32'h8, 32'h00B5_06B3);
        // Redirect mid-fetch to 0x100.
        expectReq(22, 32'hC);
        expectReq(23, 32'hD);
        for (int i = 0; i < 4; i++) expectReq(25 + i, 32'h100 + 32'(i));
        expectOut(30, 32'h100, 32'h0000_006F);
        // Redirect while stalled in OUT, to the top of the address space.
        for (int i = 0; i < 4; i++) expectReq(32 + i, 32'hFFFF_FFFC + 32'(i));
        expectOut(37, 32'hFFFF_FFFC, 32'h0000_1237);
        for (int i = 0; i < 4; i++) expectReq(38 + i, 32'(i));
        expectOut(43, 32'h0, 32'h0010_0513);
        expectReq(44, 32'h4);
        expectReq(45, 32'h5);

        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 5);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 3);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 9);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 6);
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h100, 1);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 5);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 1);
        applyStimulus(1'b0, 1'b1, 1'b1, 32'hFFFF_FFFC, 1);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 14);

        // Reset in the middle of a fetch from 0x4.
        rst = 1'b0;
        #2;
        checkResetState("midreset");
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 2);

        rst  = 1'b1;
        base = cyc;
        for (int i = 0; i < 4; i++) expectReq(i, 32'(i));
        expectOut(5, 32'h0, 32'h0010_0513);
        expectReq(6, 32'h4);
        expectReq(7, 32'h5);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 8);

        while (reqQ.size() > 0) begin
            reqExp_t re;
            re = reqQ.pop_front();
            compared++;
            mismatched++;
            $display("[TB] FAIL req: missing request cycle %0d addr %h", re.cyc, re.addr);
        end
        while (outQ.size() > 0) begin
            outExp_t oe;
            oe = outQ.pop_front();
            compared++;
            mismatched++;
            $display("[TB] FAIL out: missing word cycle %0d pc %h inst %h", oe.cyc, oe.pc, oe.inst);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
